// File: rtl/ecc_arb_pkg.sv
// Shared types and constants for the ECC point-multiplier arbiter.
// Used by ecc_arbiter and rr_pick2.
package ecc_arb_pkg;

   localparam int unsigned KEY_W_DEF = 164;
   localparam int unsigned REQ_PUB   = 0;
   localparam int unsigned REQ_SHR   = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      GAP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/ecc_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot choice among the active requests,
// favouring the requester that was not served last on a tie.
module rr_pick2
   import ecc_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] pick
);

   always_comb begin
      pick = '0;
      case (req)
         2'b01:   pick[REQ_PUB] = 1'b1;
         2'b10:   pick[REQ_SHR] = 1'b1;
         2'b11: begin
            if (last) pick[REQ_PUB] = 1'b1;
            else      pick[REQ_SHR] = 1'b1;
         end
         default: pick = '0;
      endcase
   end

endmodule

// File: rtl/ecc_arbiter.sv
// Round-robin sharing of one ECC point-multiplier core between two requesters.
// Define ECC_ARB_TIMEOUT_EN to enable the RUN-state watchdog and err pulses.
module ecc_arbiter
   import ecc_arb_pkg::*;
#(
   parameter int unsigned KEY_W          = KEY_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 4096
)
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic [1:0]       req,
   input  logic [KEY_W-1:0] scalar0,
   input  logic [KEY_W-1:0] scalar1,
   output logic [KEY_W-1:0] core_k,
   output logic             estart,
   input  logic             edone,
   input  logic [KEY_W-1:0] Pox,
   input  logic [KEY_W-1:0] Poy,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic [KEY_W-1:0] res_x,
   output logic [KEY_W-1:0] res_y,
   output logic             busy,
   output logic [1:0]       err
);

   arb_state_t state, state_nxt;
   logic [1:0] pick;
   logic       last;
   logic       timed_out;
   logic       tmo_hit;

   rr_pick2 u_pick (
      .req  (req),
      .last (last),
      .pick (pick)
   );

`ifdef ECC_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)                         cnt <= '0;
      else if (state == IDLE && (|req))   cnt <= '0;
      else if (state == RUN)              cnt <= cnt + 1'b1;
   end

   // edone in the final allowed cycle takes priority over the watchdog
   assign tmo_hit = (state == RUN) && !edone && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      estart    = 1'b0;
      busy      = 1'b1;
      core_k    = '0;
      done      = '0;
      err       = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (|req) state_nxt = RUN;
         end
         RUN: begin
            estart = 1'b1;
            core_k = gnt[REQ_SHR] ? scalar1 : scalar0;
            if (edone || tmo_hit) state_nxt = DONE;
         end
         DONE: begin
            if (timed_out) err  = gnt;
            else           done = gnt;
            state_nxt = GAP;
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // gnt is cleared on leaving DONE so it reads zero throughout GAP
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         gnt       <= '0;
         last      <= 1'b1;
         res_x     <= '0;
         res_y     <= '0;
         timed_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= pick;
                  timed_out <= 1'b0;
               end
            end
            RUN: begin
               if (edone) begin
                  res_x <= Pox;
                  res_y <= Poy;
               end else if (tmo_hit) begin
                  timed_out <= 1'b1;
               end
            end
            DONE: begin
               last <= gnt[REQ_SHR];
               gnt  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_arbiter.sv
// Scoreboard bench for ecc_arbiter: stimulus pushes expected done/err/result
// entries, a forked monitor pops and compares whenever done or err is seen.
`timescale 1ns/1ps
module tb_ecc_arbiter;
   import ecc_arb_pkg::*;

   localparam int unsigned KW  = KEY_W_DEF;
   localparam int unsigned TMO = 16;

   localparam logic [KW-1:0] S0 = {41{4'h3}};
   localparam logic [KW-1:0] S1 = {41{4'hC}};
   localparam logic [KW-1:0] X1 = {4'h5, {40{4'hA}}};
   localparam logic [KW-1:0] Y1 = {4'hA, {40{4'h5}}};
   localparam logic [KW-1:0] X2 = {{40{4'h1}}, 4'h2};
   localparam logic [KW-1:0] Y2 = {{40{4'h2}}, 4'h1};
   localparam logic [KW-1:0] X3 = {{20{8'h0F}}, 4'h7};
   localparam logic [KW-1:0] Y3 = {{20{8'hF0}}, 4'h8};
   localparam logic [KW-1:0] JUNK = {41{4'hE}};

   logic          clk = 1'b0;
   logic          n_rst;
   logic [1:0]    req;
   logic [KW-1:0] scalar0, scalar1, Pox, Poy;
   logic          edone;
   logic [KW-1:0] core_k, res_x, res_y;
   logic          estart, busy;
   logic [1:0]    gnt, done, err;

   typedef struct {
      logic [1:0]    d;
      logic [1:0]    e;
      logic [KW-1:0] x;
      logic [KW-1:0] y;
   } exp_t;

   exp_t          sbq[$];
   int            total = 0;
   int            bad   = 0;
   logic [KW-1:0] last_x, last_y;

   ecc_arbiter #(.KEY_W(KW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .req     (req),
      .scalar0 (scalar0),
      .scalar1 (scalar1),
      .core_k  (core_k),
      .estart  (estart),
      .edone   (edone),
      .Pox     (Pox),
      .Poy     (Poy),
      .gnt     (gnt),
      .done    (done),
      .res_x   (res_x),
      .res_y   (res_y),
      .busy    (busy),
      .err     (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // One serviced operation: grant seen in the first cycle, edone after lat RUN cycles.
   task automatic run_op(input logic [1:0] exp_g, input int lat,
                         input logic [KW-1:0] x, input logic [KW-1:0] y,
                         input bit drop_mid, input bit gap_edone,
                         input logic [1:0] req_after);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!estart && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("grant_lat", KW'(n), KW'(0));
      chk("gnt", KW'(gnt), KW'(exp_g));
      chk("busy_run", KW'(busy), KW'(1));
      chk("core_k", core_k, exp_g[1] ? S1 : S0);
      for (int i = 0; i < lat; i++) begin
         @(posedge clk); #1;
         if (drop_mid && i == lat / 2) req = req & ~exp_g;
      end
      edone = 1'b1;
      Pox = x;
      Poy = y;
      e.d = exp_g; e.e = 2'b00; e.x = x; e.y = y;
      sbq.push_back(e);
      last_x = x;
      last_y = y;
      @(posedge clk); #1;
      edone = 1'b0;
      Pox = JUNK;
      Poy = JUNK;
      req = req_after;
      @(negedge clk);
      chk("done_pulse", KW'(done), KW'(exp_g));
      @(posedge clk); #1;
      if (gap_edone) edone = 1'b1;
      @(negedge clk);
      chk("gap_estart", KW'(estart), KW'(0));
      chk("gap_gnt", KW'(gnt), KW'(0));
      chk("gap_busy", KW'(busy), KW'(1));
      @(posedge clk); #1;
      edone = 1'b0;
      @(negedge clk);
      chk("idle_busy", KW'(busy), KW'(0));
   endtask

   // Watchdog expiry: edone held low, err expected after TMO RUN cycles.
   task automatic run_tmo(input logic [1:0] exp_g, input logic [1:0] req_after);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!estart && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_gnt", KW'(gnt), KW'(exp_g));
      e.d = 2'b00; e.e = exp_g; e.x = last_x; e.y = last_y;
      sbq.push_back(e);
      n = 0;
      while (estart && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_run_len", KW'(n), KW'(TMO));
      chk("tmo_err", KW'(err), KW'(exp_g));
      req = req_after;
      @(negedge clk);
      chk("tmo_gap_gnt", KW'(gnt), KW'(0));
      @(negedge clk);
      chk("tmo_idle", KW'(busy), KW'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timed out");
   end

   initial begin
      n_rst = 1'b0; req = 2'b00; edone = 1'b0;
      scalar0 = S0; scalar1 = S1; Pox = JUNK; Poy = JUNK;
      last_x = '0; last_y = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", KW'(gnt), KW'(0));
      chk("rst_estart", KW'(estart), KW'(0));
      chk("rst_busy", KW'(busy), KW'(0));
      chk("rst_done_err", KW'({done, err}), KW'(0));
      chk("rst_res_x", res_x, '0);
      chk("rst_res_y", res_y, '0);
      chk("rst_core_k", core_k, '0);
      n_rst = 1'b1;

      fork
         begin
            exp_t m;
            forever begin
               @(negedge clk);
               if (done !== 2'b00 || err !== 2'b00) begin
                  if (sbq.size() == 0) begin
                     chk("unexpected_done_err", KW'({done, err}), KW'(0));
                  end else begin
                     m = sbq.pop_front();
                     chk("sb_done", KW'(done), KW'(m.d));
                     chk("sb_err", KW'(err), KW'(m.e));
                     chk("sb_res_x", res_x, m.x);
                     chk("sb_res_y", res_y, m.y);
                  end
               end
            end
         end
      join_none

      // single requester 0, edone 10 cycles after estart
      @(posedge clk); #1;
      req = 2'b01;
      @(negedge clk);
      chk("pre_grant_gnt", KW'(gnt), KW'(0));
      run_op(2'b01, 10, X1, Y1, 1'b0, 1'b0, 2'b00);

      // both held: pointer now favours requester 1
      @(posedge clk); #1;
      req = 2'b11;
      @(negedge clk);
      chk("pre_alt_gnt", KW'(gnt), KW'(0));
      run_op(2'b10, 3, X2, Y2, 1'b0, 1'b0, 2'b11);
      run_op(2'b01, 5, X3, Y3, 1'b0, 1'b0, 2'b11);
      run_op(2'b10, 1, Y1, X1, 1'b0, 1'b0, 2'b11);
      run_op(2'b01, 7, X1, Y2, 1'b0, 1'b0, 2'b00);

      // requester 1 drops mid-RUN; no re-grant afterwards
      @(posedge clk); #1;
      req = 2'b10;
      @(negedge clk);
      chk("pre_drop_gnt", KW'(gnt), KW'(0));
      run_op(2'b10, 8, X2, Y3, 1'b1, 1'b0, 2'b00);
      repeat (5) @(negedge clk);
      chk("no_regrant_estart", KW'(estart), KW'(0));
      chk("no_regrant_gnt", KW'(gnt), KW'(0));

      // stray edone in IDLE
      @(posedge clk); #1;
      edone = 1'b1; Pox = JUNK; Poy = JUNK;
      @(posedge clk); #1;
      edone = 1'b0;
      @(negedge clk);
      chk("idle_edone_busy", KW'(busy), KW'(0));
      chk("idle_edone_res", res_x, X2);

      // stray edone in GAP
      @(posedge clk); #1;
      req = 2'b01;
      @(negedge clk);
      chk("pre_gapedone_gnt", KW'(gnt), KW'(0));
      run_op(2'b01, 4, X3, Y1, 1'b0, 1'b1, 2'b00);
      chk("gap_edone_res", res_x, X3);

      // reset mid-RUN; pointer would otherwise favour requester 1
      @(posedge clk); #1;
      req = 2'b11;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_gnt", KW'(gnt), KW'(2'b10));
      @(posedge clk); #3;
      n_rst = 1'b0;
      #1;
      chk("arst_gnt", KW'(gnt), KW'(0));
      chk("arst_estart", KW'(estart), KW'(0));
      chk("arst_busy", KW'(busy), KW'(0));
      chk("arst_core_k", core_k, '0);
      chk("arst_res_x", res_x, '0);
      chk("arst_res_y", res_y, '0);
      last_x = '0; last_y = '0;
      req = 2'b00;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk); #1;
      req = 2'b11;
      @(negedge clk);
      chk("post_reset_idle", KW'(gnt), KW'(0));
      run_op(2'b01, 2, Y3, X2, 1'b0, 1'b0, 2'b11);

`ifdef ECC_ARB_TIMEOUT_EN
      // requester 1 times out, then requester 0 finishes in the last allowed cycle
      run_tmo(2'b10, 2'b11);
      chk("tmo_res_kept", res_x, Y3);
      run_op(2'b01, TMO - 1, X1, Y1, 1'b0, 1'b0, 2'b00);
`else
      @(posedge clk); #1;
      req = 2'b00;
      repeat (4) @(negedge clk);
      chk("no_err_default", KW'(err), KW'(0));
`endif

      repeat (5) @(negedge clk);
      chk("sb_empty", KW'(sbq.size()), KW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
